// File: rtl/cycle_sequencer.sv
// Cycle sequencing and interrupt entry for the 6502 core: drives I/R/S cycle
// lines from IR/cycle and forces BRK with a latched vector on interrupt entry.
module cycle_sequencer #(
    parameter int NMI_HIJACK_LAST = 3
) (
    input  logic       clk_ph1,
    input  logic       rst,
    input  logic [7:0] IR,
    input  logic [2:0] cycle,
    input  logic       page_cross,
    input  logic       branch_taken,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       i_flag,
    output logic       I_cycle,
    output logic       R_cycle,
    output logic       S_cycle,
    output logic       force_brk,
    output logic       int_active,
    output logic [1:0] vec_sel
);

    localparam logic [1:0] VEC_IRQ = 2'b00;
    localparam logic [1:0] VEC_NMI = 2'b01;
    localparam logic [1:0] VEC_RST = 2'b10;

    typedef struct packed {
        logic       branch;
        logic       skip;
        logic [2:0] fix;
        logic [2:0] last;
    } dec_t;

    // last = N-1; skip/fix mark indexed reads that may drop their fix-up cycle
    function automatic dec_t decode(input logic [7:0] op);
        dec_t       d;
        logic [2:0] aaa;
        logic [2:0] bbb;
        logic       xfer;
        aaa  = op[7:5];
        bbb  = op[4:2];
        xfer = (aaa == 3'b100) || (aaa == 3'b101);
        d    = '{branch: 1'b0, skip: 1'b0, fix: 3'd0, last: 3'd1};
        case (op[1:0])
            2'b01: begin
                case (bbb)
                    3'b000: d.last = 3'd5;
                    3'b001: d.last = 3'd2;
                    3'b010: d.last = 3'd1;
                    3'b011: d.last = 3'd3;
                    3'b100: begin d.last = 3'd5; d.skip = (aaa != 3'b100); d.fix = 3'd4; end
                    3'b101: d.last = 3'd3;
                    default: begin d.last = 3'd4; d.skip = (aaa != 3'b100); d.fix = 3'd3; end
                endcase
            end
            2'b10: begin
                case (bbb)
                    3'b001: d.last = xfer ? 3'd2 : 3'd4;
                    3'b011: d.last = xfer ? 3'd3 : 3'd5;
                    3'b101: d.last = xfer ? 3'd3 : 3'd5;
                    3'b111: begin
                        if (aaa == 3'b101) begin
                            d.last = 3'd4; d.skip = 1'b1; d.fix = 3'd3;
                        end else if (aaa != 3'b100) begin
                            d.last = 3'd6;
                        end
                    end
                    default: d.last = 3'd1;
                endcase
            end
            2'b00: begin
                case (bbb)
                    3'b000: begin
                        if (aaa == 3'b000) d.last = 3'd6;
                        else if (aaa <= 3'b011) d.last = 3'd5;
                    end
                    3'b001: if (aaa == 3'b001 || aaa >= 3'b100) d.last = 3'd2;
                    3'b010: begin
                        if (aaa == 3'b000 || aaa == 3'b010) d.last = 3'd2;
                        else if (aaa == 3'b001 || aaa == 3'b011) d.last = 3'd3;
                    end
                    3'b011: begin
                        if (aaa == 3'b010) d.last = 3'd2;
                        else if (aaa == 3'b011) d.last = 3'd4;
                        else if (aaa != 3'b000) d.last = 3'd3;
                    end
                    3'b100: d.branch = 1'b1;
                    3'b101: if (xfer) d.last = 3'd3;
                    3'b111: if (aaa == 3'b101) begin d.last = 3'd4; d.skip = 1'b1; d.fix = 3'd3; end
                    default: d.last = 3'd1;
                endcase
            end
            default: d.last = 3'd1;
        endcase
        return d;
    endfunction

    logic       nmi_hist_q, nmi_hist_d;
    logic       nmi_pend_q, nmi_pend_d;
    logic       rst_pend_q, rst_pend_d;
    logic       take_int_q, take_int_d;
    logic       int_active_q, int_active_d;
    logic [1:0] vec_sel_q, vec_sel_d;
    logic [7:0] ir_eff;
    dec_t       dec;
    logic       nmi_edge, brk_c6;

    assign force_brk  = ~rst & take_int_q & (cycle == 3'd0);
    // The forced BRK is sequenced as opcode 0x00 regardless of what IR holds
    assign ir_eff     = (force_brk || int_active_q) ? 8'h00 : IR;
    assign int_active = int_active_q;
    assign vec_sel    = vec_sel_q;

    always_comb begin
        dec     = decode(ir_eff);
        I_cycle = 1'b0;
        R_cycle = 1'b0;
        S_cycle = 1'b0;
        if (!rst) begin
            if (cycle == 3'd7) begin
                R_cycle = 1'b1;
            end else if (dec.branch) begin
                case (cycle)
                    3'd0:    I_cycle = 1'b1;
                    3'd1:    begin I_cycle = branch_taken; R_cycle = ~branch_taken; end
                    3'd2:    begin I_cycle = page_cross;   R_cycle = ~page_cross;   end
                    default: R_cycle = 1'b1;
                endcase
            end else if (cycle == dec.last) begin
                R_cycle = 1'b1;
            end else if (dec.skip && cycle == dec.fix && !page_cross) begin
                S_cycle = 1'b1;
            end else begin
                I_cycle = 1'b1;
            end
        end
    end

    // Pending flags are evaluated with this cycle's edge and clears applied,
    // so the take sample at R_cycle sees exactly what will be registered.
    always_comb begin
        nmi_edge     = nmi_hist_q & ~nmi_n;
        brk_c6       = int_active_q & (cycle == 3'd6);
        nmi_hist_d   = nmi_n;
        nmi_pend_d   = nmi_edge | (nmi_pend_q & ~(brk_c6 & (vec_sel_q == VEC_NMI)));
        rst_pend_d   = rst_pend_q & ~(brk_c6 & (vec_sel_q == VEC_RST));
        take_int_d   = take_int_q;
        vec_sel_d    = vec_sel_q;
        int_active_d = int_active_q;
        if (R_cycle) begin
            take_int_d = rst_pend_d | nmi_pend_d | (~irq_n & ~i_flag);
            vec_sel_d  = rst_pend_d ? VEC_RST : (nmi_pend_d ? VEC_NMI : VEC_IRQ);
        end else begin
            if (force_brk) take_int_d = 1'b0;
            if ((int_active_q || force_brk) && vec_sel_q == VEC_IRQ && nmi_pend_d
                && int'(cycle) <= NMI_HIJACK_LAST)
                vec_sel_d = VEC_NMI;
        end
        if (force_brk) int_active_d = 1'b1;
        else if (R_cycle) int_active_d = 1'b0;
    end

    always_ff @(posedge clk_ph1) begin
        if (rst) begin
            nmi_hist_q   <= 1'b1;
            nmi_pend_q   <= 1'b0;
            rst_pend_q   <= 1'b1;
            take_int_q   <= 1'b0;
            int_active_q <= 1'b0;
            vec_sel_q    <= VEC_RST;
        end else begin
            nmi_hist_q   <= nmi_hist_d;
            nmi_pend_q   <= nmi_pend_d;
            rst_pend_q   <= rst_pend_d;
            take_int_q   <= take_int_d;
            int_active_q <= int_active_d;
            vec_sel_q    <= vec_sel_d;
        end
    end

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: expected outputs are queued with each
// stimulus step and compared when the step is sampled.
module tb_cycle_sequencer;

    logic       clk_ph1 = 1'b0;
    logic       rst;
    logic [7:0] IR;
    logic [2:0] cycle;
    logic       page_cross, branch_taken, nmi_n, irq_n, i_flag;
    logic       I_cycle, R_cycle, S_cycle, force_brk, int_active;
    logic [1:0] vec_sel;

    int checks = 0;
    int errors = 0;
    int step_no = 0;

    typedef struct packed {
        logic [2:0] irs;
        logic       fb;
        logic       ia;
        logic [1:0] vs;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [2:0] EI = 3'b100;
    localparam logic [2:0] ER = 3'b010;
    localparam logic [2:0] ES = 3'b001;

    cycle_sequencer #(.NMI_HIJACK_LAST(3)) dut (
        .clk_ph1(clk_ph1), .rst(rst), .IR(IR), .cycle(cycle),
        .page_cross(page_cross), .branch_taken(branch_taken),
        .nmi_n(nmi_n), .irq_n(irq_n), .i_flag(i_flag),
        .I_cycle(I_cycle), .R_cycle(R_cycle), .S_cycle(S_cycle),
        .force_brk(force_brk), .int_active(int_active), .vec_sel(vec_sel)
    );

    always #5 clk_ph1 = ~clk_ph1;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s step %0d observed=%0h expected=%0h", tag, step_no, obs, expv);
        end
    endtask

    task automatic step(input logic [7:0] ir, input logic [2:0] cyc, input logic pc,
                        input logic bt, input logic [2:0] irs, input logic fb,
                        input logic ia, input logic [1:0] vs);
        exp_t e;
        IR           = ir;
        cycle        = cyc;
        page_cross   = pc;
        branch_taken = bt;
        exp_q.push_back('{irs: irs, fb: fb, ia: ia, vs: vs});
        @(negedge clk_ph1);
        e = exp_q.pop_front();
        chk("irs", {5'b0, I_cycle, R_cycle, S_cycle}, {5'b0, e.irs});
        chk("force_brk", {7'b0, force_brk}, {7'b0, e.fb});
        chk("int_active", {7'b0, int_active}, {7'b0, e.ia});
        chk("vec_sel", {6'b0, vec_sel}, {6'b0, e.vs});
        step_no++;
        @(posedge clk_ph1);
        #1;
    endtask

    task automatic nop(input logic [1:0] vs);
        step(8'hEA, 3'd0, 1'b0, 1'b0, EI, 1'b0, 1'b0, vs);
        step(8'hEA, 3'd1, 1'b0, 1'b0, ER, 1'b0, 1'b0, vs);
    endtask

    task automatic brk_body(input logic [1:0] vs);
        for (int c = 1; c <= 5; c++)
            step(8'h00, 3'(c), 1'b0, 1'b0, EI, 1'b0, 1'b1, vs);
        step(8'h00, 3'd6, 1'b0, 1'b0, ER, 1'b0, 1'b1, vs);
    endtask

    initial begin
        rst = 1'b1; IR = 8'hEA; cycle = 3'd7; page_cross = 1'b0; branch_taken = 1'b0;
        nmi_n = 1'b1; irq_n = 1'b1; i_flag = 1'b1;
        repeat (2) @(posedge clk_ph1);
        #1;
        chk("rst_irs", {5'b0, I_cycle, R_cycle, S_cycle}, 8'h00);
        chk("rst_force_brk", {7'b0, force_brk}, 8'h00);
        chk("rst_int_active", {7'b0, int_active}, 8'h00);
        chk("rst_vec_sel", {6'b0, vec_sel}, 8'h02);
        rst = 1'b0;

        // Reset entry: cycle 7 -> R, then forced BRK through the RESET vector
        step(8'hEA, 3'd7, 1'b0, 1'b0, ER, 1'b0, 1'b0, 2'b10);
        step(8'hEA, 3'd0, 1'b0, 1'b0, EI, 1'b1, 1'b0, 2'b10);
        brk_body(2'b10);
        nop(2'b00);

        // LDA abs,X without and with page cross; STA abs,X never skips
        step(8'hBD, 3'd0, 1'b0, 1'b0, EI, 1'b0, 1'b0, 2'b00);
        step(8'hBD, 3'd1, 1'b0, 1'b0, EI, 1'b0, 1'b0, 2'b00);
        step(8'hBD, 3'd2, 1'b0, 1'b0, EI, 1'b0, 1'b0, 2'b00);
        step(8'hBD, 3'd3, 1'b0, 1'b0, ES, 1'b0, 1'b0, 2'b00);
        step(8'hBD, 3'd4, 1'b0, 1'b0, ER, 1'b0, 1'b0, 2'b00);
        for (int c = 0; c <= 3; c++)
            step(8'hBD, 3'(c), 1'b1, 1'b0, EI, 1'b0, 1'b0, 2'b00);
        step(8'hBD, 3'd4, 1'b1, 1'b0, ER, 1'b0, 1'b0, 2'b00);
        step(8'h9D, 3'd3, 1'b0, 1'b0, EI, 1'b0, 1'b0, 2'b00);
        step(8'h9D, 3'd4, 1'b0, 1'b0, ER, 1'b0, 1'b0, 2'b00);
        step(8'hFE, 3'd3, 1'b0, 1'b0, EI, 1'b0, 1'b0, 2'b00);
        step(8'hFE, 3'd5, 1'b0, 1'b0, EI, 1'b0, 1'b0, 2'b00);
        step(8'hFE, 3'd6, 1'b0, 1'b0, ER, 1'b0, 1'b0, 2'b00);
        step(8'hB1, 3'd4, 1'b0, 1'b0, ES, 1'b0, 1'b0, 2'b00);
        step(8'hB1, 3'd5, 1'b0, 1'b0, ER, 1'b0, 1'b0, 2'b00);
        step(8'h4C, 3'd2, 1'b0, 1'b0, ER, 1'b0, 1'b0, 2'b00);
        step(8'h20, 3'd4, 1'b0, 1'b0, EI, 1'b0, 1'b0, 2'b00);
        step(8'h20, 3'd5, 1'b0, 1'b0, ER, 1'b0, 1'b0, 2'b00);
        step(8'h68, 3'd3, 1'b0, 1'b0, ER, 1'b0, 1'b0, 2'b00);

        // BNE: not taken, taken without cross, taken with cross
        step(8'hD0, 3'd0, 1'b0, 1'b0, EI, 1'b0, 1'b0, 2'b00);
        step(8'hD0, 3'd1, 1'b0, 1'b0, ER, 1'b0, 1'b0, 2'b00);
        step(8'hD0, 3'd0, 1'b0, 1'b1, EI, 1'b0, 1'b0, 2'b00);
        step(8'hD0, 3'd1, 1'b0, 1'b1, EI, 1'b0, 1'b0, 2'b00);
        step(8'hD0, 3'd2, 1'b0, 1'b1, ER, 1'b0, 1'b0, 2'b00);
        step(8'hD0, 3'd1, 1'b0, 1'b1, EI, 1'b0, 1'b0, 2'b00);
        step(8'hD0, 3'd2, 1'b1, 1'b1, EI, 1'b0, 1'b0, 2'b00);
        step(8'hD0, 3'd3, 1'b1, 1'b1, ER, 1'b0, 1'b0, 2'b00);

        // IRQ masked, then unmasked at an R cycle; NMI edge at cycle 2 hijacks
        irq_n = 1'b0;
        nop(2'b00);
        step(8'hEA, 3'd0, 1'b0, 1'b0, EI, 1'b0, 1'b0, 2'b00);
        i_flag = 1'b0;
        step(8'hEA, 3'd1, 1'b0, 1'b0, ER, 1'b0, 1'b0, 2'b00);
        step(8'hEA, 3'd0, 1'b0, 1'b0, EI, 1'b1, 1'b0, 2'b00);
        irq_n = 1'b1;
        step(8'h00, 3'd1, 1'b0, 1'b0, EI, 1'b0, 1'b1, 2'b00);
        nmi_n = 1'b0;
        step(8'h00, 3'd2, 1'b0, 1'b0, EI, 1'b0, 1'b1, 2'b00);
        step(8'h00, 3'd3, 1'b0, 1'b0, EI, 1'b0, 1'b1, 2'b01);
        step(8'h00, 3'd4, 1'b0, 1'b0, EI, 1'b0, 1'b1, 2'b01);
        step(8'h00, 3'd5, 1'b0, 1'b0, EI, 1'b0, 1'b1, 2'b01);
        step(8'h00, 3'd6, 1'b0, 1'b0, ER, 1'b0, 1'b1, 2'b01);
        nop(2'b00);

        // NMI edge coincident with R_cycle is taken; held low gives one entry
        nmi_n = 1'b1;
        nop(2'b00);
        step(8'hEA, 3'd0, 1'b0, 1'b0, EI, 1'b0, 1'b0, 2'b00);
        nmi_n = 1'b0;
        step(8'hEA, 3'd1, 1'b0, 1'b0, ER, 1'b0, 1'b0, 2'b00);
        step(8'hEA, 3'd0, 1'b0, 1'b0, EI, 1'b1, 1'b0, 2'b01);
        brk_body(2'b01);
        for (int k = 0; k < 6; k++) nop(2'b00);

        // NMI edge after the hijack window: IRQ vector kept, NMI entry follows
        nmi_n = 1'b1;
        step(8'hEA, 3'd0, 1'b0, 1'b0, EI, 1'b0, 1'b0, 2'b00);
        irq_n = 1'b0;
        step(8'hEA, 3'd1, 1'b0, 1'b0, ER, 1'b0, 1'b0, 2'b00);
        irq_n = 1'b1;
        step(8'hEA, 3'd0, 1'b0, 1'b0, EI, 1'b1, 1'b0, 2'b00);
        for (int c = 1; c <= 3; c++)
            step(8'h00, 3'(c), 1'b0, 1'b0, EI, 1'b0, 1'b1, 2'b00);
        nmi_n = 1'b0;
        step(8'h00, 3'd4, 1'b0, 1'b0, EI, 1'b0, 1'b1, 2'b00);
        step(8'h00, 3'd5, 1'b0, 1'b0, EI, 1'b0, 1'b1, 2'b00);
        step(8'h00, 3'd6, 1'b0, 1'b0, ER, 1'b0, 1'b1, 2'b00);
        step(8'hEA, 3'd0, 1'b0, 1'b0, EI, 1'b1, 1'b0, 2'b01);
        brk_body(2'b01);
        nop(2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
